// File: rtl/axi4_slave_pkg.sv
// Shared types and burst legality rule for the AXI4 memory slave.
package axi4_slave_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } resp_t;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rd_state_t;

    localparam int unsigned BOUNDARY_4K = 4096;

    // A burst is illegal if it runs past the last memory word, crosses a
    // 4 KB page, or asks for a beat wider than the 32-bit word.
    function automatic logic burst_error(input logic [31:0] addr,
                                         input logic [7:0]  len,
                                         input logic [2:0]  size,
                                         input int unsigned depth);
        int unsigned index;
        int unsigned beats;
        int unsigned bytes;
        index = addr >> 2;
        beats = 32'(len) + 32'd1;
        bytes = beats << size;
        return (index + beats > depth)
            || ((addr % BOUNDARY_4K) + bytes > BOUNDARY_4K)
            || (size > 3'd2);
    endfunction

endpackage

// File: rtl/axi4_mem_ram.sv
// Simple dual-port RAM: one write port, one registered read port with enable.
module axi4_mem_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_WIDTH-1:0]    wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_WIDTH-1:0]    rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Write port and read-before-write registered read port; rdata holds when re is low.
    // NOTE: the array has no reset; clearing a RAM needs a write sweep, and a reset term would stop it mapping onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/axi4_mem_slave.sv
// AXI4 slave answering INCR bursts from a word-addressed on-chip memory.
// Read and write paths are independent FSMs; illegal bursts get SLVERR and
// never touch memory.
module axi4_mem_slave
    import axi4_slave_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 16,
    parameter int MEMORY_DEPTH = 1024
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic [ADDR_WIDTH-1:0] AWADDR,
    input  logic [7:0]            AWLEN,
    input  logic [2:0]            AWSIZE,
    input  logic                  AWVALID,
    output logic                  AWREADY,
    input  logic [DATA_WIDTH-1:0] WDATA,
    input  logic                  WLAST,
    input  logic                  WVALID,
    output logic                  WREADY,
    output logic [1:0]            BRESP,
    output logic                  BVALID,
    input  logic                  BREADY,
    input  logic [ADDR_WIDTH-1:0] ARADDR,
    input  logic [7:0]            ARLEN,
    input  logic [2:0]            ARSIZE,
    input  logic                  ARVALID,
    output logic                  ARREADY,
    output logic [DATA_WIDTH-1:0] RDATA,
    output logic [1:0]            RRESP,
    output logic                  RLAST,
    output logic                  RVALID,
    input  logic                  RREADY
);

    localparam int IDX_W = $clog2(MEMORY_DEPTH);

    // ---------------- write path ----------------
    wr_state_t         wr_state, wr_state_nxt;
    logic              aw_ready_q;
    logic [IDX_W-1:0]  wr_index;
    logic [7:0]        wr_len, wr_beat;
    logic              wr_err, wr_last_bad;
    logic              aw_hs, w_hs, b_hs;

    assign aw_hs   = AWVALID && aw_ready_q;
    assign w_hs    = WVALID && (wr_state == W_DATA);
    assign b_hs    = BREADY && (wr_state == W_RESP);
    assign AWREADY = aw_ready_q;
    assign WREADY  = (wr_state == W_DATA);
    assign BVALID  = (wr_state == W_RESP);
    assign BRESP   = (BVALID && (wr_err || wr_last_bad)) ? SLVERR : OKAY;

    // Write next-state: burst length comes from AWLEN, never from WLAST.
    // NOTE: every combinational output gets a default first so no path leaves it unassigned and infers a latch.
    always_comb begin
        wr_state_nxt = wr_state;
        unique case (wr_state)
            W_IDLE:  if (aw_hs) wr_state_nxt = W_DATA;
            W_DATA:  if (w_hs && (wr_beat == wr_len)) wr_state_nxt = W_RESP;
            W_RESP:  if (b_hs) wr_state_nxt = W_IDLE;
            default: wr_state_nxt = W_IDLE;
        endcase
    end

    // Write state register, burst context and WLAST consistency tracking.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wr_state    <= W_IDLE;
            aw_ready_q  <= 1'b0;
            wr_index    <= '0;
            wr_len      <= '0;
            wr_beat     <= '0;
            wr_err      <= 1'b0;
            wr_last_bad <= 1'b0;
        end else begin
            wr_state   <= wr_state_nxt;
            aw_ready_q <= (wr_state_nxt == W_IDLE);
            if (aw_hs) begin
                wr_index    <= AWADDR[IDX_W+1:2];
                wr_len      <= AWLEN;
                wr_beat     <= '0;
                wr_err      <= burst_error(32'(AWADDR), AWLEN, AWSIZE, 32'(MEMORY_DEPTH));
                wr_last_bad <= 1'b0;
            end else if (w_hs) begin
                wr_index <= wr_index + 1'b1;
                wr_beat  <= wr_beat + 1'b1;
                if (WLAST != (wr_beat == wr_len)) begin
                    wr_last_bad <= 1'b1;
                end
            end
        end
    end

    // ---------------- read path ----------------
    rd_state_t             rd_state, rd_state_nxt;
    logic                  ar_ready_q;
    logic [IDX_W-1:0]      rd_index;
    logic [7:0]            rd_len, rd_beat;
    logic                  rd_err;
    logic                  ar_hs, r_hs;
    logic [DATA_WIDTH-1:0] ram_rdata;

    assign ar_hs   = ARVALID && ar_ready_q;
    assign r_hs    = RREADY && (rd_state == R_DATA);
    assign ARREADY = ar_ready_q;
    assign RVALID  = (rd_state == R_DATA);
    assign RLAST   = RVALID && (rd_beat == rd_len);
    assign RDATA   = (RVALID && !rd_err) ? ram_rdata : '0;
    assign RRESP   = (RVALID && rd_err) ? SLVERR : OKAY;

    // Read next-state: one fetch cycle before every beat.
    always_comb begin
        rd_state_nxt = rd_state;
        unique case (rd_state)
            R_IDLE:  if (ar_hs) rd_state_nxt = R_FETCH;
            R_FETCH: rd_state_nxt = R_DATA;
            R_DATA:  if (r_hs) rd_state_nxt = (rd_beat == rd_len) ? R_IDLE : R_FETCH;
            default: rd_state_nxt = R_IDLE;
        endcase
    end

    // Read state register and burst context.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            rd_state   <= R_IDLE;
            ar_ready_q <= 1'b0;
            rd_index   <= '0;
            rd_len     <= '0;
            rd_beat    <= '0;
            rd_err     <= 1'b0;
        end else begin
            rd_state   <= rd_state_nxt;
            ar_ready_q <= (rd_state_nxt == R_IDLE);
            if (ar_hs) begin
                rd_index <= ARADDR[IDX_W+1:2];
                rd_len   <= ARLEN;
                rd_beat  <= '0;
                rd_err   <= burst_error(32'(ARADDR), ARLEN, ARSIZE, 32'(MEMORY_DEPTH));
            end else if (r_hs && (rd_beat != rd_len)) begin
                rd_index <= rd_index + 1'b1;
                rd_beat  <= rd_beat + 1'b1;
            end
        end
    end

    // The RAM read register only loads in R_FETCH, so RDATA holds through RREADY stalls.
    axi4_mem_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (MEMORY_DEPTH)
    ) u_ram (
        .clk  (ACLK),
        .we   (w_hs && !wr_err),
        .waddr(wr_index),
        .wdata(WDATA),
        .re   ((rd_state == R_FETCH) && !rd_err),
        .raddr(rd_index),
        .rdata(ram_rdata)
    );

endmodule
